// File: rtl/axi_lite_reg_pkg.sv
// rtl/axi_lite_reg_pkg.sv - shared constants and state types for the AXI4-Lite register slave
package axi_lite_reg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word index (address bits [4:2]) of each register
  localparam logic [2:0] REG_CTRL0  = 3'd0;
  localparam logic [2:0] REG_CTRL1  = 3'd1;
  localparam logic [2:0] REG_CTRL2  = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Indices above the status register fall in the unmapped upper half
  function automatic logic reg_in_range(input logic [2:0] idx);
    return idx <= REG_STATUS;
  endfunction

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// rtl/axi_lite_reg_slave_if.sv - AXI4-Lite bus bundle with master and slave views
interface axi_lite_reg_slave_if
  import axi_lite_reg_pkg::*;
();

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_reg_wstrb_merge.sv
// rtl/axi_lite_reg_wstrb_merge.sv - byte-strobe merge of new write data over a register's old value
module axi_lite_reg_wstrb_merge #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_data,
  input  logic [DATA_W-1:0]   new_data,
  input  logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0]   merged_data
);

  // Each enabled byte lane takes the new byte, the rest keep the old one
  always_comb begin
    merged_data = old_data;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (strb[i]) merged_data[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// rtl/axi_lite_reg_slave.sv - AXI4-Lite slave with three control registers and one status register
module axi_lite_reg_slave
  import axi_lite_reg_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  axi_lite_reg_slave_if.slave           s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] CTRL0,
  output logic [C_S_AXI_DATA_WIDTH-1:0] CTRL1,
  output logic [C_S_AXI_DATA_WIDTH-1:0] CTRL2,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] STATUS_IN
);

  localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;

  wr_state_t                     wr_state_q, wr_state_d;
  rd_state_t                     rd_state_q, rd_state_d;
  logic                          aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]                 wstrb_q, wstrb_d;
  logic                          awready_q, awready_d, wready_q, wready_d;
  logic                          bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]                    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl0_q, ctrl0_d, ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d;

  logic                          aw_hs, w_hs, ar_hs;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data, merge_old, merge_new;
  logic [SW-1:0]                 wr_strb;
  logic [2:0]                    wr_idx, rd_idx;
  logic                          unused_bits;

  assign aw_hs = s_axi.awvalid & awready_q;
  assign w_hs  = s_axi.wvalid & wready_q;
  assign ar_hs = s_axi.arvalid & arready_q;

  // A channel latched on an earlier edge wins over what is on the bus now
  assign wr_addr = aw_done_q ? awaddr_q : s_axi.awaddr;
  assign wr_data = w_done_q  ? wdata_q  : s_axi.wdata;
  assign wr_strb = w_done_q  ? wstrb_q  : s_axi.wstrb;
  assign wr_idx  = wr_addr[4:2];
  assign rd_idx  = s_axi.araddr[4:2];

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Pick the current contents of the addressed control register for merging
  always_comb begin
    merge_old = '0;
    case (wr_idx)
      REG_CTRL0: merge_old = ctrl0_q;
      REG_CTRL1: merge_old = ctrl1_q;
      REG_CTRL2: merge_old = ctrl2_q;
      default:   merge_old = '0;
    endcase
  end

  axi_lite_reg_wstrb_merge #(.DATA_W(C_S_AXI_DATA_WIDTH)) u_merge (
    .old_data    (merge_old),
    .new_data    (wr_data),
    .strb        (wr_strb),
    .merged_data (merge_new)
  );

  // Write FSM: latch AW and W independently, commit once both are held, then hold B
  always_comb begin
    wr_state_d = wr_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    ctrl0_d    = ctrl0_q;
    ctrl1_d    = ctrl1_q;
    ctrl2_d    = ctrl2_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          awaddr_d  = s_axi.awaddr;
        end
        if (w_hs) begin
          w_done_d = 1'b1;
          wdata_d  = s_axi.wdata;
          wstrb_d  = s_axi.wstrb;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          case (wr_idx)
            REG_CTRL0: ctrl0_d = merge_new;
            REG_CTRL1: ctrl1_d = merge_new;
            REG_CTRL2: ctrl2_d = merge_new;
            default:   ;
          endcase
          bresp_d    = reg_in_range(wr_idx) ? RESP_OKAY : RESP_SLVERR;
          bvalid_d   = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    awready_d = (wr_state_d == W_IDLE) && !aw_done_d;
    wready_d  = (wr_state_d == W_IDLE) && !w_done_d;
  end

  // Read FSM: capture the addressed register on the AR handshake, hold R until accepted
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          case (rd_idx)
            REG_CTRL0:  rdata_d = ctrl0_q;
            REG_CTRL1:  rdata_d = ctrl1_q;
            REG_CTRL2:  rdata_d = ctrl2_q;
            REG_STATUS: rdata_d = STATUS_IN;
            default:    rdata_d = '0;
          endcase
          rresp_d    = reg_in_range(rd_idx) ? RESP_OKAY : RESP_SLVERR;
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    arready_d = (rd_state_d == R_IDLE);
  end

  // State and registered outputs; reset drops any transaction in flight
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      ctrl0_q    <= '0;
      ctrl1_q    <= '0;
      ctrl2_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      ctrl0_q    <= ctrl0_d;
      ctrl1_q    <= ctrl1_d;
      ctrl2_q    <= ctrl2_d;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;
  assign CTRL0 = ctrl0_q;
  assign CTRL1 = ctrl1_q;
  assign CTRL2 = ctrl2_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb/tb_axi_lite_reg_slave.sv - directed self-checking bench for axi_lite_reg_slave
module tb_axi_lite_reg_slave;
  import axi_lite_reg_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] ctrl0, ctrl1, ctrl2, status_in;
  int          checks = 0;
  int          errors = 0;

  axi_lite_reg_slave_if bus ();

  axi_lite_reg_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (resetn),
    .s_axi         (bus),
    .CTRL0         (ctrl0),
    .CTRL1         (ctrl1),
    .CTRL2         (ctrl2),
    .STATUS_IN     (status_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic flag_of(input int which);
    case (which)
      0:       return bus.awready;
      1:       return bus.wready;
      2:       return bus.arready;
      default: return 1'b0;
    endcase
  endfunction

  // Wait (sampling on negedge) until the selected ready is high, bounded
  task automatic wait_ready(input int which, input string tag);
    int n = 0;
    while (flag_of(which) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  // AW handshake, gap idle cycles, then W handshake; leaves B pending
  task automatic send_aw_w(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int gap);
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    wait_ready(0, "awready");
    @(negedge clk);
    bus.awvalid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wvalid = 1'b1;
    wait_ready(1, "wready");
    @(negedge clk);
    bus.wvalid = 1'b0;
  endtask

  // Check B is up, optionally stall it, then accept it
  task automatic take_b(input int bp, input logic [1:0] exp_resp, input string tag);
    check({tag, " bvalid"}, 32'(bus.bvalid), 32'd1);
    check({tag, " bresp"}, 32'(bus.bresp), 32'(exp_resp));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check({tag, " bvalid held"}, 32'(bus.bvalid), 32'd1);
      check({tag, " bresp held"}, 32'(bus.bresp), 32'(exp_resp));
      check({tag, " no aw/w accept"}, 32'({bus.awready, bus.wready}), 32'd0);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check({tag, " bvalid drop"}, 32'(bus.bvalid), 32'd0);
  endtask

  task automatic send_ar(input logic [4:0] addr);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    wait_ready(2, "arready");
    @(negedge clk);
    bus.arvalid = 1'b0;
  endtask

  task automatic take_r(input int bp, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                        input string tag);
    check({tag, " rvalid"}, 32'(bus.rvalid), 32'd1);
    check({tag, " rdata"}, bus.rdata, exp_data);
    check({tag, " rresp"}, 32'(bus.rresp), 32'(exp_resp));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check({tag, " rvalid held"}, 32'(bus.rvalid), 32'd1);
      check({tag, " rdata held"}, bus.rdata, exp_data);
      check({tag, " no ar accept"}, 32'(bus.arready), 32'd0);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check({tag, " rvalid drop"}, 32'(bus.rvalid), 32'd0);
  endtask

  initial begin
    resetn      = 1'b0;
    status_in   = 32'h0;
    bus.awaddr  = '0;
    bus.awprot  = '0;
    bus.awvalid = 1'b1;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arprot  = '0;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;

    // Reset held with requests pending
    repeat (20) @(negedge clk);
    check("rst readies", 32'({bus.awready, bus.wready, bus.arready}), 32'd0);
    check("rst valids", 32'({bus.bvalid, bus.rvalid}), 32'd0);
    check("rst ctrl0", ctrl0, 32'h0);
    check("rst ctrl1", ctrl1, 32'h0);
    check("rst ctrl2", ctrl2, 32'h0);
    check("rst rdata", bus.rdata, 32'h0);
    bus.awvalid = 1'b0;
    bus.arvalid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    // AW first, W three cycles later
    send_aw_w(5'h04, 32'hDEADBEEF, 4'hF, 3);
    take_b(0, RESP_OKAY, "wr ctrl1");
    check("ctrl1 value", ctrl1, 32'hDEADBEEF);
    send_ar(5'h04);
    take_r(0, 32'hDEADBEEF, RESP_OKAY, "rd ctrl1");

    // Partial strobe merge
    send_aw_w(5'h00, 32'h11223344, 4'hF, 0);
    take_b(0, RESP_OKAY, "wr ctrl0 full");
    send_aw_w(5'h01, 32'hAABBCCDD, 4'b0101, 0);
    take_b(0, RESP_OKAY, "wr ctrl0 part");
    check("ctrl0 merged", ctrl0, 32'h11BB33DD);

    // Out-of-range accesses
    send_aw_w(5'h10, 32'hFFFFFFFF, 4'hF, 1);
    take_b(0, RESP_SLVERR, "wr 0x10");
    send_ar(5'h1C);
    take_r(0, 32'h0, RESP_SLVERR, "rd 0x1C");
    check("oor ctrl0", ctrl0, 32'h11BB33DD);
    check("oor ctrl1", ctrl1, 32'hDEADBEEF);
    check("oor ctrl2", ctrl2, 32'h0);

    // Write to status is ignored but OKAY
    send_aw_w(5'h0C, 32'h55555555, 4'hF, 0);
    take_b(0, RESP_OKAY, "wr status");

    // Backpressure on B and R
    send_aw_w(5'h08, 32'h12345678, 4'hF, 0);
    take_b(5, RESP_OKAY, "bp wr ctrl2");
    check("ctrl2 value", ctrl2, 32'h12345678);
    status_in = 32'hCAFE0001;
    send_ar(5'h0C);
    take_r(5, 32'hCAFE0001, RESP_OKAY, "bp rd status");

    // Same-edge read and write commit of CTRL2: read sees old value
    check("sim awready", 32'(bus.awready), 32'd1);
    check("sim arready", 32'(bus.arready), 32'd1);
    bus.awaddr  = 5'h08;
    bus.wdata   = 32'h0;
    bus.wstrb   = 4'hF;
    bus.araddr  = 5'h08;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.arvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
    check("sim ctrl2 new", ctrl2, 32'h0);
    take_r(0, 32'h12345678, RESP_OKAY, "sim rd");
    take_b(0, RESP_OKAY, "sim wr");

    // Reset while a write response is pending
    send_aw_w(5'h00, 32'hFFFFFFFF, 4'hF, 0);
    check("pre-rst bvalid", 32'(bus.bvalid), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("mid-rst bvalid", 32'(bus.bvalid), 32'd0);
    check("mid-rst ctrl0", ctrl0, 32'h0);
    check("mid-rst ctrl1", ctrl1, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    send_aw_w(5'h04, 32'h5A5A5A5A, 4'b0011, 1);
    take_b(0, RESP_OKAY, "post-rst wr");
    check("post-rst ctrl1", ctrl1, 32'h00005A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
